// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stall/flush requests into the per-stage hold vector and runs the EX multi-cycle counter.
// Optional statistics counters are built when PIPE_CTRL_STATS_EN is defined.
module pipe_ctrl #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id,
  input  logic             ex_mc_start,
  input  logic [CNT_W-1:0] ex_mc_cycles,
  input  logic             stallreq_mem,
  input  logic             flush_req,
  input  logic [31:0]      flush_pc,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic             ex_mc_done,
  output logic             ex_busy,
  input  logic             stats_clr,
  output logic [31:0]      stall_cycles,
  output logic [15:0]      flush_cnt
);

  typedef enum logic {RUN, MULTI} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ex_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_stall = ((state_q == RUN) && ex_mc_start && (ex_mc_cycles > CNT_W'(1))) ||
                    ((state_q == MULTI) && (cnt_q != CNT_W'(1)));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall      = 6'b000000;
    flush      = 1'b0;
    new_pc     = 32'h0;
    ex_mc_done = 1'b0;
    // Outputs are forced quiet while reset is held, independent of the clock
    if (!rst) begin
      if (flush_req) begin
        flush   = 1'b1;
        new_pc  = flush_pc;
        state_d = RUN;
        cnt_d   = '0;
      end else begin
        if (stallreq_mem)     stall = 6'b011111;
        else if (ex_stall)    stall = 6'b001111;
        else if (stallreq_id) stall = 6'b000111;

        case (state_q)
          RUN: begin
            if (ex_mc_start) begin
              if (ex_mc_cycles > CNT_W'(1)) begin
                cnt_d   = ex_mc_cycles - CNT_W'(1);
                state_d = MULTI;
              end else begin
                ex_mc_done = 1'b1;
              end
            end
          end
          MULTI: begin
            // A memory wait freezes the count so the op finishes one cycle later
            if (!stallreq_mem) begin
              if (cnt_q == CNT_W'(1)) begin
                ex_mc_done = 1'b1;
                state_d    = RUN;
                cnt_d      = '0;
              end else begin
                cnt_d = cnt_q - CNT_W'(1);
              end
            end
          end
          default: begin
            state_d = RUN;
            cnt_d   = '0;
          end
        endcase
      end
    end
  end

  assign ex_busy = (state_q == MULTI);

`ifdef PIPE_CTRL_STATS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_cnt_d    = flush_cnt_q;
    if (stats_clr) begin
      stall_cycles_d = '0;
      flush_cnt_d    = '0;
    end else begin
      if (stall[0] && (stall_cycles_q != 32'hFFFF_FFFF)) stall_cycles_d = stall_cycles_q + 32'd1;
      if (flush && (flush_cnt_q != 16'hFFFF))           flush_cnt_d    = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_cnt_q    <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_cnt_q    <= flush_cnt_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_cnt    = flush_cnt_q;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
  assign stall_cycles     = 32'h0;
  assign flush_cnt        = 16'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: each cycle's stimulus and expected outputs are queued together,
// then popped and compared at the falling edge of that cycle.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_id;
  logic        ex_mc_start;
  logic [4:0]  ex_mc_cycles;
  logic        stallreq_mem;
  logic        flush_req;
  logic [31:0] flush_pc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        ex_mc_done;
  logic        ex_busy;
  logic        stats_clr;
  logic [31:0] stall_cycles;
  logic [15:0] flush_cnt;

  typedef struct packed {
    logic        id;
    logic        start;
    logic [4:0]  n;
    logic        mem;
    logic        fl;
    logic [31:0] pc;
    logic        clr;
  } stim_t;

  typedef struct packed {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        done;
    logic        busy;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int    checks = 0;
  int    passes = 0;

`ifdef PIPE_CTRL_STATS_EN
  localparam logic [31:0] EXP_STALLS  = 32'd3;
  localparam logic [15:0] EXP_FLUSHES = 16'd1;
`else
  localparam logic [31:0] EXP_STALLS  = 32'd0;
  localparam logic [15:0] EXP_FLUSHES = 16'd0;
`endif

  pipe_ctrl #(.CNT_W(5)) dut (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .ex_mc_start(ex_mc_start),
    .ex_mc_cycles(ex_mc_cycles), .stallreq_mem(stallreq_mem), .flush_req(flush_req),
    .flush_pc(flush_pc), .stall(stall), .flush(flush), .new_pc(new_pc),
    .ex_mc_done(ex_mc_done), .ex_busy(ex_busy), .stats_clr(stats_clr),
    .stall_cycles(stall_cycles), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic id, input logic st, input logic [4:0] n, input logic mem,
                     input logic fl, input logic [31:0] pc, input logic clr,
                     input logic [5:0] e_stall, input logic e_flush, input logic [31:0] e_pc,
                     input logic e_done, input logic e_busy);
    stim_t s;
    exp_t  e;
    s = '{id: id, start: st, n: n, mem: mem, fl: fl, pc: pc, clr: clr};
    e = '{stall: e_stall, flush: e_flush, new_pc: e_pc, done: e_done, busy: e_busy};
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic apply(input stim_t s);
    stallreq_id  = s.id;
    ex_mc_start  = s.start;
    ex_mc_cycles = s.n;
    stallreq_mem = s.mem;
    flush_req    = s.fl;
    flush_pc     = s.pc;
    stats_clr    = s.clr;
  endtask

  task automatic test_reset;
    stim_t s;
    exp_t  e, o;
    int    cyc = 0;
    rst = 1'b1;
    add(0, 0, 5'd0, 0, 0, 32'h0,         0, 6'h00, 0, 32'h0, 0, 0);
    add(1, 1, 5'd4, 1, 1, 32'h1234_5678, 1, 6'h00, 0, 32'h0, 0, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s);
      @(negedge clk);
      e = exp_q.pop_front();
      o = {stall, flush, new_pc, ex_mc_done, ex_busy};
      checks++;
      if (o !== e) $display("[TB] FAIL reset_hold cyc %0d: got %h expected %h", cyc, o, e);
      else passes++;
      @(posedge clk); #1; cyc++;
    end
    rst = 1'b0;
    checks++;
    if ({stall_cycles, flush_cnt} !== 48'h0) $display("[TB] FAIL reset_stats: got %h expected 0", {stall_cycles, flush_cnt});
    else passes++;
    for (int i = 0; i < 5; i++) add(0, 0, 5'd0, 0, 0, 32'h0, 0, 6'h00, 0, 32'h0, 0, 0);
    add(0, 1, 5'd8, 0, 0, 32'h0, 0, 6'h0F, 0, 32'h0, 0, 0);
    add(0, 0, 5'd0, 0, 0, 32'h0, 0, 6'h0F, 0, 32'h0, 0, 1);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s);
      @(negedge clk);
      e = exp_q.pop_front();
      o = {stall, flush, new_pc, ex_mc_done, ex_busy};
      checks++;
      if (o !== e) $display("[TB] FAIL reset_idle cyc %0d: got %h expected %h", cyc, o, e);
      else passes++;
      @(posedge clk); #1; cyc++;
    end
    #6 rst = 1'b1;
    #1;
    o = {stall, flush, new_pc, ex_mc_done, ex_busy};
    checks++;
    if (o !== exp_t'(0)) $display("[TB] FAIL reset_async: got %h expected 0", o);
    else passes++;
    @(posedge clk); #1 rst = 1'b0;
    add(0, 0, 5'd0, 0, 0, 32'h0, 0, 6'h00, 0, 32'h0, 0, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s);
      @(negedge clk);
      e = exp_q.pop_front();
      o = {stall, flush, new_pc, ex_mc_done, ex_busy};
      checks++;
      if (o !== e) $display("[TB] FAIL reset_drop cyc %0d: got %h expected %h", cyc, o, e);
      else passes++;
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic test_id_stall;
    stim_t s;
    exp_t  e, o;
    int    cyc = 0;
    add(1, 0, 5'd0, 0, 0, 32'h0, 0, 6'h07, 0, 32'h0, 0, 0);
    add(1, 0, 5'd0, 0, 0, 32'h0, 0, 6'h07, 0, 32'h0, 0, 0);
    add(0, 0, 5'd0, 0, 0, 32'h0, 0, 6'h00, 0, 32'h0, 0, 0);
    add(1, 0, 5'd0, 1, 0, 32'h0, 0, 6'h1F, 0, 32'h0, 0, 0);
    add(0, 0, 5'd0, 0, 0, 32'h0, 0, 6'h00, 0, 32'h0, 0, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s);
      @(negedge clk);
      e = exp_q.pop_front();
      o = {stall, flush, new_pc, ex_mc_done, ex_busy};
      checks++;
      if (o !== e) $display("[TB] FAIL id_stall cyc %0d: got %h expected %h", cyc, o, e);
      else passes++;
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic test_multi_cycle;
    stim_t s;
    exp_t  e, o;
    int    cyc = 0;
    add(0, 1, 5'd4, 0, 0, 32'h0, 0, 6'h0F, 0, 32'h0, 0, 0);
    add(0, 0, 5'd0, 0, 0, 32'h0, 0, 6'h0F, 0, 32'h0, 0, 1);
    add(0, 0, 5'd0, 0, 0, 32'h0, 0, 6'h0F, 0, 32'h0, 0, 1);
    add(0, 0, 5'd0, 0, 0, 32'h0, 0, 6'h00, 0, 32'h0, 1, 1);
    add(0, 0, 5'd0, 0, 0, 32'h0, 0, 6'h00, 0, 32'h0, 0, 0);
    add(0, 1, 5'd1, 0, 0, 32'h0, 0, 6'h00, 0, 32'h0, 1, 0);
    add(0, 1, 5'd0, 0, 0, 32'h0, 0, 6'h00, 0, 32'h0, 1, 0);
    add(0, 1, 5'd3, 0, 0, 32'h0, 0, 6'h0F, 0, 32'h0, 0, 0);
    add(0, 1, 5'd5, 0, 0, 32'h0, 0, 6'h0F, 0, 32'h0, 0, 1);
    add(1, 0, 5'd0, 0, 0, 32'h0, 0, 6'h07, 0, 32'h0, 1, 1);
    add(0, 0, 5'd0, 0, 0, 32'h0, 0, 6'h00, 0, 32'h0, 0, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s);
      @(negedge clk);
      e = exp_q.pop_front();
      o = {stall, flush, new_pc, ex_mc_done, ex_busy};
      checks++;
      if (o !== e) $display("[TB] FAIL multi_cycle cyc %0d: got %h expected %h", cyc, o, e);
      else passes++;
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic test_mem_extend;
    stim_t s;
    exp_t  e, o;
    int    cyc = 0;
    add(0, 1, 5'd4, 0, 0, 32'h0, 0, 6'h0F, 0, 32'h0, 0, 0);
    add(0, 0, 5'd0, 1, 0, 32'h0, 0, 6'h1F, 0, 32'h0, 0, 1);
    add(0, 0, 5'd0, 0, 0, 32'h0, 0, 6'h0F, 0, 32'h0, 0, 1);
    add(0, 0, 5'd0, 0, 0, 32'h0, 0, 6'h0F, 0, 32'h0, 0, 1);
    add(0, 0, 5'd0, 0, 0, 32'h0, 0, 6'h00, 0, 32'h0, 1, 1);
    add(0, 0, 5'd0, 0, 0, 32'h0, 0, 6'h00, 0, 32'h0, 0, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s);
      @(negedge clk);
      e = exp_q.pop_front();
      o = {stall, flush, new_pc, ex_mc_done, ex_busy};
      checks++;
      if (o !== e) $display("[TB] FAIL mem_extend cyc %0d: got %h expected %h", cyc, o, e);
      else passes++;
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic test_flush;
    stim_t s;
    exp_t  e, o;
    int    cyc = 0;
    add(0, 1, 5'd8, 0, 0, 32'h0,         0, 6'h0F, 0, 32'h0,         0, 0);
    add(0, 0, 5'd0, 0, 0, 32'h0,         0, 6'h0F, 0, 32'h0,         0, 1);
    add(1, 0, 5'd0, 1, 1, 32'h8000_0180, 0, 6'h00, 1, 32'h8000_0180, 0, 1);
    add(0, 0, 5'd0, 0, 0, 32'h0,         0, 6'h00, 0, 32'h0,         0, 0);
    add(0, 0, 5'd0, 0, 0, 32'h0,         0, 6'h00, 0, 32'h0,         0, 0);
    add(0, 1, 5'd6, 0, 1, 32'h0000_0040, 0, 6'h00, 1, 32'h0000_0040, 0, 0);
    add(0, 0, 5'd0, 0, 0, 32'h0,         0, 6'h00, 0, 32'h0,         0, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s);
      @(negedge clk);
      e = exp_q.pop_front();
      o = {stall, flush, new_pc, ex_mc_done, ex_busy};
      checks++;
      if (o !== e) $display("[TB] FAIL flush cyc %0d: got %h expected %h", cyc, o, e);
      else passes++;
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic test_stats;
    stim_t s;
    exp_t  e, o;
    int    cyc = 0;
    add(0, 0, 5'd0, 0, 0, 32'h0,  1, 6'h00, 0, 32'h0,  0, 0);
    add(1, 0, 5'd0, 0, 0, 32'h0,  0, 6'h07, 0, 32'h0,  0, 0);
    add(1, 0, 5'd0, 0, 0, 32'h0,  0, 6'h07, 0, 32'h0,  0, 0);
    add(1, 0, 5'd0, 0, 0, 32'h0,  0, 6'h07, 0, 32'h0,  0, 0);
    add(0, 0, 5'd0, 0, 1, 32'h100, 0, 6'h00, 1, 32'h100, 0, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s);
      @(negedge clk);
      e = exp_q.pop_front();
      o = {stall, flush, new_pc, ex_mc_done, ex_busy};
      checks++;
      if (o !== e) $display("[TB] FAIL stats_seq cyc %0d: got %h expected %h", cyc, o, e);
      else passes++;
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (stall_cycles !== EXP_STALLS) $display("[TB] FAIL stall_cycles: got %0d expected %0d", stall_cycles, EXP_STALLS);
    else passes++;
    checks++;
    if (flush_cnt !== EXP_FLUSHES) $display("[TB] FAIL flush_cnt: got %0d expected %0d", flush_cnt, EXP_FLUSHES);
    else passes++;
    add(1, 0, 5'd0, 0, 0, 32'h0, 1, 6'h07, 0, 32'h0, 0, 0);
    s = stim_q.pop_front(); apply(s);
    @(negedge clk);
    e = exp_q.pop_front();
    o = {stall, flush, new_pc, ex_mc_done, ex_busy};
    checks++;
    if (o !== e) $display("[TB] FAIL stats_clr_cycle: got %h expected %h", o, e);
    else passes++;
    @(posedge clk); #1;
    apply(stim_t'(0));
    checks++;
    if ({stall_cycles, flush_cnt} !== 48'h0) $display("[TB] FAIL stats_clr: got %h expected 0", {stall_cycles, flush_cnt});
    else passes++;
  endtask

  initial begin
    rst = 1'b1;
    apply(stim_t'(0));
    test_reset();
    test_id_stall();
    test_multi_cycle();
    test_mem_extend();
    test_flush();
    test_stats();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
